mem_req_ctrl: RTL and testbench

Request controller between the pipeline's memory stage and `mem_system`. It accepts one load or store per transaction and holds `Addr`/`DataIn`/`Rd`/`Wr` stable into `mem_system` until `Done`. It stalls the pipeline for the whole transaction and returns read data with a one-cycle completion pulse. It also rejects misaligned or malformed requests, aborts hung transactions via a watchdog, and keeps saturating hit/miss counters for performance dumps.

---
 rtl/mem_req_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Purpose: controller for one outstanding load/store between the memory stage and mem_system.
// Latency: if mem_done arrives in REQ cycle k, pipe_done is at cycle k+1. Rejected requests complete at cycle 1.
// Backpressure: pipe_stall holds the pipeline for the whole REQ phase. Only mem_done or the watchdog ends REQ.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   pipe_valid/rd/wr/addr/wdata : request from the memory stage
//   pipe_stall/done/rdata/err   : stall, completion pulse, load data, error pulse to the pipeline
//   mem_addr/data_in/rd/wr      : registered request into mem_system, stable for all of REQ
//   mem_data_out/done/stall/hit/err : response from mem_system
//   hit_count/miss_count        : saturating counters of completed transactions
module mem_req_ctrl #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic        pipe_rd,
  input  logic        pipe_wr,
  input  logic [15:0] pipe_addr,
  input  logic [15:0] pipe_wdata,
  output logic        pipe_stall,
  output logic        pipe_done,
  output logic [15:0] pipe_rdata,
  output logic        pipe_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_hit,
  input  logic        mem_err,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // The watchdog reads 0 in the first REQ cycle. It therefore reads TIMEOUT-1 in the last cycle allowed.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wdog_q;
  logic        err_q;
  logic [15:0] rdata_q;
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  logic accepted;
  logic malformed;
  logic aligned;
  logic start_req;
  logic wdog_last;

  // mem_done alone marks completion, so mem_system's stall indication carries no extra information here.
  logic unused_mem_stall;
  assign unused_mem_stall = mem_stall;

  assign accepted  = pipe_valid & (pipe_rd ^ pipe_wr);
  assign malformed = pipe_valid & pipe_rd & pipe_wr;
  assign aligned   = ~pipe_addr[0];
  assign start_req = (state_q == ST_IDLE) & accepted & aligned;
  assign wdog_last = (wdog_q == WDOG_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and pipeline-facing outputs
  always_comb begin
    state_d    = state_q;
    pipe_stall = 1'b0;
    pipe_done  = 1'b0;
    pipe_err   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accepted && aligned) begin
          state_d    = ST_REQ;
          // Stall in the accept cycle as well, so the memory stage holds until pipe_done.
          pipe_stall = 1'b1;
        end else if (accepted || malformed) begin
          state_d = ST_ERR;
        end
      end
      ST_REQ: begin
        pipe_stall = 1'b1;
        // When mem_done and watchdog expiry coincide, both lead to DONE. The datapath block gives mem_done priority.
        if (mem_done || wdog_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        pipe_done = 1'b1;
        pipe_err  = err_q;
        state_d   = ST_IDLE;
      end
      ST_ERR: begin
        pipe_done = 1'b1;
        pipe_err  = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request registers, watchdog, response capture and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr    <= 16'h0000;
      mem_data_in <= 16'h0000;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      wdog_q      <= 8'h00;
      err_q       <= 1'b0;
      rdata_q     <= 16'h0000;
      hit_cnt_q   <= 16'h0000;
      miss_cnt_q  <= 16'h0000;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            mem_addr    <= pipe_addr;
            mem_data_in <= pipe_wdata;
            mem_rd      <= pipe_rd;
            mem_wr      <= pipe_wr;
            wdog_q      <= 8'h00;
            err_q       <= 1'b0;
          end
        end
        ST_REQ: begin
          wdog_q <= wdog_q + 8'd1;
          if (mem_done) begin
            // mem_rd still holds the latched op, so it selects loads here.
            if (mem_rd) begin
              rdata_q <= mem_data_out;
            end
            if (mem_hit) begin
              if (hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
              end
            end else begin
              if (miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
              end
            end
            err_q  <= mem_err;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
          end else if (wdog_last) begin
            // Abandon the hung access. The counters stay unchanged because nothing completed.
            err_q  <= 1'b1;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pipe_rdata = rdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Purpose: self-checking bench for mem_req_ctrl, using directed transactions with hand-computed expectations.
// Latency: inputs are driven 1 time unit after the rising edge and outputs are sampled 1 unit later.
// Backpressure: the bench plays mem_system and raises mem_done on a fixed, scripted cycle.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, pipe_rd, pipe_wr;
  logic [15:0] pipe_addr, pipe_wdata;
  logic [15:0] mem_data_out;
  logic        mem_done, mem_stall, mem_hit, mem_err;

  logic        pipe_stall, pipe_done, pipe_err, mem_rd, mem_wr;
  logic [15:0] pipe_rdata, mem_addr, mem_data_in, hit_count, miss_count;

  logic        t5_pipe_stall, t5_pipe_done, t5_pipe_err, t5_mem_rd, t5_mem_wr;
  logic [15:0] t5_pipe_rdata, t5_mem_addr, t5_mem_data_in, t5_hit_count, t5_miss_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_req_ctrl u_dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_wr(pipe_wr),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall), .pipe_done(pipe_done), .pipe_rdata(pipe_rdata), .pipe_err(pipe_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_hit(mem_hit), .mem_err(mem_err),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  mem_req_ctrl #(.TIMEOUT(5)) u_t5 (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_wr(pipe_wr),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(t5_pipe_stall), .pipe_done(t5_pipe_done), .pipe_rdata(t5_pipe_rdata), .pipe_err(t5_pipe_err),
    .mem_addr(t5_mem_addr), .mem_data_in(t5_mem_data_in), .mem_rd(t5_mem_rd), .mem_wr(t5_mem_wr),
    .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_hit(mem_hit), .mem_err(mem_err),
    .hit_count(t5_hit_count), .miss_count(t5_miss_count)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0; pipe_rd = 1'b0; pipe_wr = 1'b0;
    pipe_addr = 16'h0000; pipe_wdata = 16'h0000;
    mem_data_out = 16'h0000; mem_done = 1'b0; mem_stall = 1'b0; mem_hit = 1'b0; mem_err = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", pipe_stall); end
    checks++; if (pipe_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", pipe_done); end
    checks++; if (pipe_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", pipe_err); end
    checks++; if (pipe_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", pipe_rdata); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (mem_data_in !== 16'h0000) begin failures++; $display("FAIL reset_mem_data_in got=%0h exp=0", mem_data_in); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%0h exp=0", mem_rd); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%0h exp=0", mem_wr); end
    checks++; if (hit_count !== 16'h0000) begin failures++; $display("FAIL reset_hit got=%0h exp=0", hit_count); end
    checks++; if (miss_count !== 16'h0000) begin failures++; $display("FAIL reset_miss got=%0h exp=0", miss_count); end
    rst = 1'b0;
  endtask

  task automatic test_load_hit();
    next_cycle();  // cycle 0: accept
    pipe_valid = 1'b1; pipe_rd = 1'b1; pipe_addr = 16'h0010;
    #1;
    checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL lh_stall_c0 got=%0h exp=1", pipe_stall); end
    next_cycle();  // cycle 1: first REQ cycle, memory answers
    pipe_valid = 1'b0; pipe_rd = 1'b0; pipe_addr = 16'h0000;
    mem_done = 1'b1; mem_hit = 1'b1; mem_data_out = 16'hBEEF;
    #1;
    checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL lh_stall_c1 got=%0h exp=1", pipe_stall); end
    checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL lh_mem_rd_c1 got=%0h exp=1", mem_rd); end
    checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL lh_mem_addr got=%0h exp=0010", mem_addr); end
    checks++; if (pipe_done !== 1'b0) begin failures++; $display("FAIL lh_done_c1 got=%0h exp=0", pipe_done); end
    next_cycle();  // cycle 2: DONE
    mem_done = 1'b0; mem_hit = 1'b0; mem_data_out = 16'h0000;
    #1;
    checks++; if (pipe_done !== 1'b1) begin failures++; $display("FAIL lh_done_c2 got=%0h exp=1", pipe_done); end
    checks++; if (pipe_err !== 1'b0) begin failures++; $display("FAIL lh_err_c2 got=%0h exp=0", pipe_err); end
    checks++; if (pipe_rdata !== 16'hBEEF) begin failures++; $display("FAIL lh_rdata got=%0h exp=beef", pipe_rdata); end
    checks++; if (hit_count !== 16'd1) begin failures++; $display("FAIL lh_hit got=%0d exp=1", hit_count); end
    checks++; if (miss_count !== 16'd0) begin failures++; $display("FAIL lh_miss got=%0d exp=0", miss_count); end
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL lh_stall_c2 got=%0h exp=0", pipe_stall); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL lh_mem_rd_c2 got=%0h exp=0", mem_rd); end
    next_cycle();  // cycle 3: back in IDLE, the read data is held
    checks++; if (pipe_done !== 1'b0) begin failures++; $display("FAIL lh_done_c3 got=%0h exp=0", pipe_done); end
    checks++; if (pipe_rdata !== 16'hBEEF) begin failures++; $display("FAIL lh_rdata_hold got=%0h exp=beef", pipe_rdata); end
  endtask

  task automatic test_store_miss();
    next_cycle();  // cycle 0
    pipe_valid = 1'b1; pipe_wr = 1'b1; pipe_addr = 16'h0020; pipe_wdata = 16'h1234;
    #1;
    checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL sm_stall_c0 got=%0h exp=1", pipe_stall); end
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      idle_inputs();
      mem_data_out = 16'hDEAD;
      mem_done = (k == 20);
      #1;
      checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin failures++; $display("FAIL sm_op_c%0d got=wr%0h rd%0h exp=wr1 rd0", k, mem_wr, mem_rd); end
      checks++; if (mem_addr !== 16'h0020 || mem_data_in !== 16'h1234) begin failures++; $display("FAIL sm_bus_c%0d got=%0h/%0h exp=0020/1234", k, mem_addr, mem_data_in); end
      checks++; if (pipe_stall !== 1'b1 || pipe_done !== 1'b0) begin failures++; $display("FAIL sm_stall_c%0d got=stall%0h done%0h exp=stall1 done0", k, pipe_stall, pipe_done); end
    end
    next_cycle();  // cycle 21: DONE
    idle_inputs();
    #1;
    checks++; if (pipe_done !== 1'b1 || pipe_err !== 1'b0) begin failures++; $display("FAIL sm_done got=done%0h err%0h exp=done1 err0", pipe_done, pipe_err); end
    checks++; if (miss_count !== 16'd1 || hit_count !== 16'd1) begin failures++; $display("FAIL sm_counts got=hit%0d miss%0d exp=hit1 miss1", hit_count, miss_count); end
    checks++; if (pipe_rdata !== 16'hBEEF) begin failures++; $display("FAIL sm_rdata_unchanged got=%0h exp=beef", pipe_rdata); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL sm_mem_wr_done got=%0h exp=0", mem_wr); end
  endtask

  task automatic test_misaligned_malformed();
    for (int v = 0; v < 2; v++) begin
      next_cycle();  // cycle 0
      pipe_valid = 1'b1; pipe_rd = 1'b1; pipe_wr = (v == 1);
      pipe_addr = (v == 0) ? 16'h0021 : 16'h0030;
      #1;
      checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL rej%0d_stall_c0 got=%0h exp=0", v, pipe_stall); end
      next_cycle();  // cycle 1: ERR
      idle_inputs();
      #1;
      checks++; if (pipe_done !== 1'b1 || pipe_err !== 1'b1) begin failures++; $display("FAIL rej%0d_done got=done%0h err%0h exp=done1 err1", v, pipe_done, pipe_err); end
      checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin failures++; $display("FAIL rej%0d_mem_c1 got=rd%0h wr%0h exp=0/0", v, mem_rd, mem_wr); end
      checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL rej%0d_stall_c1 got=%0h exp=0", v, pipe_stall); end
      next_cycle();  // cycle 2: IDLE
      checks++; if (pipe_done !== 1'b0 || pipe_err !== 1'b0 || mem_rd !== 1'b0) begin failures++; $display("FAIL rej%0d_c2 got=done%0h err%0h rd%0h exp=0/0/0", v, pipe_done, pipe_err, mem_rd); end
      checks++; if (hit_count !== 16'd1 || miss_count !== 16'd1) begin failures++; $display("FAIL rej%0d_counts got=hit%0d miss%0d exp=1/1", v, hit_count, miss_count); end
    end
    // Valid with neither op is ignored.
    next_cycle();
    pipe_valid = 1'b1; pipe_addr = 16'h0040;
    #1;
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL ign_stall got=%0h exp=0", pipe_stall); end
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (pipe_done !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin failures++; $display("FAIL ign_c1 got=done%0h rd%0h wr%0h exp=0/0/0", pipe_done, mem_rd, mem_wr); end
  endtask

  task automatic test_mem_err();
    next_cycle();
    pipe_valid = 1'b1; pipe_rd = 1'b1; pipe_addr = 16'h0060;
    next_cycle();
    idle_inputs();
    mem_done = 1'b1; mem_hit = 1'b0; mem_err = 1'b1; mem_data_out = 16'h1111;
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (pipe_done !== 1'b1 || pipe_err !== 1'b1) begin failures++; $display("FAIL merr_done got=done%0h err%0h exp=1/1", pipe_done, pipe_err); end
    checks++; if (miss_count !== 16'd2 || pipe_rdata !== 16'h1111) begin failures++; $display("FAIL merr_data got=miss%0d rdata%0h exp=2/1111", miss_count, pipe_rdata); end
  endtask

  task automatic test_timeout();
    apply_reset();
    next_cycle();  // cycle 0
    pipe_valid = 1'b1; pipe_rd = 1'b1; pipe_addr = 16'h0040;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      idle_inputs();
      #1;
      checks++; if (t5_pipe_done !== 1'b0 || t5_mem_rd !== 1'b1) begin failures++; $display("FAIL to_c%0d got=done%0h rd%0h exp=done0 rd1", k, t5_pipe_done, t5_mem_rd); end
    end
    next_cycle();  // cycle 6
    checks++; if (t5_pipe_done !== 1'b1 || t5_pipe_err !== 1'b1) begin failures++; $display("FAIL to_done got=done%0h err%0h exp=1/1", t5_pipe_done, t5_pipe_err); end
    checks++; if (t5_hit_count !== 16'd0 || t5_miss_count !== 16'd0) begin failures++; $display("FAIL to_counts got=hit%0d miss%0d exp=0/0", t5_hit_count, t5_miss_count); end
    checks++; if (t5_mem_rd !== 1'b0) begin failures++; $display("FAIL to_mem_rd got=%0h exp=0", t5_mem_rd); end
    // mem_done in the watchdog's last cycle counts as a normal completion.
    next_cycle();  // cycle 0 of the second load
    pipe_valid = 1'b1; pipe_rd = 1'b1; pipe_addr = 16'h0042;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      idle_inputs();
      if (k == 5) begin
        mem_done = 1'b1; mem_hit = 1'b1; mem_data_out = 16'hCAFE;
      end
    end
    next_cycle();  // cycle 6
    idle_inputs();
    #1;
    checks++; if (t5_pipe_done !== 1'b1 || t5_pipe_err !== 1'b0) begin failures++; $display("FAIL to_edge_done got=done%0h err%0h exp=1/0", t5_pipe_done, t5_pipe_err); end
    checks++; if (t5_hit_count !== 16'd1 || t5_pipe_rdata !== 16'hCAFE) begin failures++; $display("FAIL to_edge_data got=hit%0d rdata%0h exp=1/cafe", t5_hit_count, t5_pipe_rdata); end
    apply_reset();
  endtask

  task automatic test_reset_mid_req();
    next_cycle();  // cycle 0
    pipe_valid = 1'b1; pipe_rd = 1'b1; pipe_addr = 16'h0050;
    next_cycle();  // cycle 1
    idle_inputs();
    next_cycle();  // cycle 2
    next_cycle();  // cycle 3
    checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL rmid_pending got=%0h exp=1", mem_rd); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b0 || pipe_stall !== 1'b0 || pipe_done !== 1'b0) begin failures++; $display("FAIL rmid_after got=rd%0h stall%0h done%0h exp=0/0/0", mem_rd, pipe_stall, pipe_done); end
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin failures++; $display("FAIL rmid_counts got=hit%0d miss%0d exp=0/0", hit_count, miss_count); end
    next_cycle();
    checks++; if (pipe_done !== 1'b0 || mem_rd !== 1'b0) begin failures++; $display("FAIL rmid_later got=done%0h rd%0h exp=0/0", pipe_done, mem_rd); end
  endtask

  task automatic test_back_to_back_sat();
    logic [16:0] exp_hit;
    force u_dut.hit_cnt_q = 16'hFFFD;
    next_cycle();
    release u_dut.hit_cnt_q;
    for (int i = 0; i < 4; i++) begin
      exp_hit = 17'h0FFFD + 17'(i + 1);
      if (exp_hit > 17'h0FFFF) exp_hit = 17'h0FFFF;
      next_cycle();  // IDLE: accept
      idle_inputs();
      pipe_valid = 1'b1; pipe_rd = 1'b1; pipe_addr = 16'h0100 + 16'(i * 2);
      #1;
      checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL b2b%0d_stall got=%0h exp=1", i, pipe_stall); end
      next_cycle();  // REQ: immediate hit
      idle_inputs();
      mem_done = 1'b1; mem_hit = 1'b1; mem_data_out = 16'hA000 + 16'(i);
      #1;
      checks++; if (mem_rd !== 1'b1 || pipe_done !== 1'b0) begin failures++; $display("FAIL b2b%0d_req got=rd%0h done%0h exp=1/0", i, mem_rd, pipe_done); end
      next_cycle();  // DONE
      idle_inputs();
      #1;
      checks++; if (mem_rd !== 1'b0 || pipe_done !== 1'b1) begin failures++; $display("FAIL b2b%0d_done got=rd%0h done%0h exp=0/1", i, mem_rd, pipe_done); end
      checks++; if (hit_count !== exp_hit[15:0]) begin failures++; $display("FAIL b2b%0d_hit got=%0h exp=%0h", i, hit_count, exp_hit[15:0]); end
      checks++; if (pipe_rdata !== 16'hA000 + 16'(i)) begin failures++; $display("FAIL b2b%0d_rdata got=%0h exp=%0h", i, pipe_rdata, 16'hA000 + 16'(i)); end
    end
    force u_dut.miss_cnt_q = 16'hFFFF;
    next_cycle();
    release u_dut.miss_cnt_q;
    pipe_valid = 1'b1; pipe_wr = 1'b1; pipe_addr = 16'h0200; pipe_wdata = 16'h5555;
    next_cycle();
    idle_inputs();
    mem_done = 1'b1;
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (miss_count !== 16'hFFFF || hit_count !== 16'hFFFF) begin failures++; $display("FAIL sat_miss got=miss%0h hit%0h exp=ffff/ffff", miss_count, hit_count); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_load_hit();
    test_store_miss();
    test_misaligned_malformed();
    test_mem_err();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
